// File: rtl/otter_muldiv_pkg.sv
// otter_muldiv_pkg
//   Shared definitions for the OTTER RV32M multiply/divide unit: data width,
//   iteration count, funct3 operation codes and FSM state encoding, plus a
//   magnitude helper used when latching signed operands.
//   Configuration macro: OTTER_MULDIV_DIV_EN (consumed by otter_muldiv).
package otter_muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITERS = 32;
    localparam int unsigned CNT_W = $clog2(ITERS);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } muldiv_state_t;

    // Absolute value of v when it is treated as signed; 0x80000000 maps to
    // itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                            input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/otter_muldiv_if.sv
// otter_muldiv_if
//   Request/result bundle between the OTTER control path and the muldiv unit.
//   master: drives MULDIV_START/OP/SRC_A/SRC_B, receives RESULT/BUSY/DONE.
//   slave : the muldiv unit side.
interface otter_muldiv_if;
    import otter_muldiv_pkg::*;

    logic            MULDIV_START;
    logic [2:0]      MULDIV_OP;
    logic [XLEN-1:0] MULDIV_SRC_A;
    logic [XLEN-1:0] MULDIV_SRC_B;
    logic [XLEN-1:0] MULDIV_RESULT;
    logic            MULDIV_BUSY;
    logic            MULDIV_DONE;

    modport master (
        output MULDIV_START, MULDIV_OP, MULDIV_SRC_A, MULDIV_SRC_B,
        input  MULDIV_RESULT, MULDIV_BUSY, MULDIV_DONE
    );

    modport slave (
        input  MULDIV_START, MULDIV_OP, MULDIV_SRC_A, MULDIV_SRC_B,
        output MULDIV_RESULT, MULDIV_BUSY, MULDIV_DONE
    );

endinterface

// File: rtl/otter_div_step.sv
// otter_div_step
//   One combinational restoring-division step.
//   i_part    : shifted partial remainder {rem, next dividend bit}
//   i_divisor : divisor magnitude
//   o_rem     : next partial remainder
//   o_qbit    : quotient bit produced by this step
module otter_div_step
    import otter_muldiv_pkg::*;
(
    input  logic [XLEN:0]   i_part,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    logic [XLEN:0] w_diff;

    // The running remainder stays below the divisor, so i_part < 2*divisor
    // and a non-negative difference always fits in XLEN bits.
    assign w_diff = i_part - {1'b0, i_divisor};
    assign o_qbit = ~w_diff[XLEN];
    assign o_rem  = o_qbit ? w_diff[XLEN-1:0] : i_part[XLEN-1:0];

endmodule

// File: rtl/otter_muldiv.sv
// otter_muldiv
//   Iterative RV32M multiply/divide unit (32 iterations per op). Operates in
//   parallel with the ALU on the selected source operands.
//   Ports:
//     CLK : system clock (rising edge)
//     RST : asynchronous active-high reset
//     bus : otter_muldiv_if.slave (START/OP/SRC_A/SRC_B in; RESULT/BUSY/DONE out)
//   Configuration macro: OTTER_MULDIV_DIV_EN builds the divider; without it,
//   divide ops complete in one edge with RESULT = 0.
module otter_muldiv
    import otter_muldiv_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    otter_muldiv_if.slave bus
);

    muldiv_state_t     r_state, w_state_next;
    muldiv_op_t        r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_p;      // product {hi, multiplier} or {rem, dividend/quotient}
    logic [XLEN-1:0]   r_b;      // multiplicand or divisor magnitude
    logic              r_neg;    // result negation (product or quotient)
    logic [XLEN-1:0]   r_result;

    muldiv_op_t        w_op_in;
    logic              w_is_div, w_accept, w_last;
    logic              w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_p_mul, w_p_next, w_prod;
    logic [XLEN-1:0]   w_fixed;

    assign w_op_in  = muldiv_op_t'(bus.MULDIV_OP);
    assign w_is_div = bus.MULDIV_OP[2];
    assign w_accept = bus.MULDIV_START && (r_state != CALC);
    assign w_last   = (r_cnt == CNT_W'(ITERS - 1));

    assign w_a_neg = (w_op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.MULDIV_SRC_A[XLEN-1];
    assign w_b_neg = (w_op_in inside {OP_MULH, OP_DIV, OP_REM}) && bus.MULDIV_SRC_B[XLEN-1];
    assign w_a_mag = mag(bus.MULDIV_SRC_A, w_a_neg);
    assign w_b_mag = mag(bus.MULDIV_SRC_B, w_b_neg);

    // Shift-add: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole 65-bit {carry, hi, lo} right by one.
    assign w_sum   = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_b} : '0);
    assign w_p_mul = {w_sum, r_p[XLEN-1:1]};

`ifdef OTTER_MULDIV_DIV_EN
    logic              r_rem_neg;
    logic [XLEN-1:0]   w_div_rem;
    logic              w_div_q;
    logic [2*XLEN-1:0] w_p_div;

    otter_div_step u_div_step (
        .i_part    ({r_p[2*XLEN-1:XLEN], r_p[XLEN-1]}),
        .i_divisor (r_b),
        .o_rem     (w_div_rem),
        .o_qbit    (w_div_q)
    );

    // Dividend bits shift out of the low half as quotient bits shift in.
    assign w_p_div  = {w_div_rem, r_p[XLEN-2:0], w_div_q};
    assign w_p_next = r_op[2] ? w_p_div : w_p_mul;
`else
    assign w_p_next = w_p_mul;
`endif

    assign w_prod = r_neg ? -w_p_next : w_p_next;

    always_comb begin
        w_fixed = '0;
        case (r_op)
            OP_MUL:                         w_fixed = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   w_fixed = w_prod[2*XLEN-1:XLEN];
`ifdef OTTER_MULDIV_DIV_EN
            OP_DIV, OP_DIVU:                w_fixed = r_neg ? -w_p_next[XLEN-1:0] : w_p_next[XLEN-1:0];
            OP_REM, OP_REMU:                w_fixed = r_rem_neg ? -w_p_next[2*XLEN-1:XLEN]
                                                                : w_p_next[2*XLEN-1:XLEN];
`endif
            default:                        w_fixed = '0;
        endcase
    end

    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
`ifdef OTTER_MULDIV_DIV_EN
        if (w_is_div) begin
            if (bus.MULDIV_SRC_B == '0) begin
                w_special     = 1'b1;
                w_special_res = bus.MULDIV_OP[1] ? bus.MULDIV_SRC_A : '1;
            end else if (!bus.MULDIV_OP[0] && bus.MULDIV_SRC_A == {1'b1, {(XLEN-1){1'b0}}}
                         && bus.MULDIV_SRC_B == '1) begin
                w_special     = 1'b1;
                w_special_res = bus.MULDIV_OP[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end
        end
`else
        if (w_is_div) begin
            w_special     = 1'b1;
            w_special_res = '0;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, FIN: begin
                if (w_accept) w_state_next = w_special ? FIN : CALC;
                else          w_state_next = IDLE;
            end
            CALC:    if (w_last) w_state_next = FIN;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_op      <= OP_MUL;
            r_cnt     <= '0;
            r_p       <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
`ifdef OTTER_MULDIV_DIV_EN
            r_rem_neg <= 1'b0;
`endif
            r_result  <= '0;
        end else if (w_accept) begin
            r_op      <= w_op_in;
            r_cnt     <= '0;
            r_neg     <= w_a_neg ^ w_b_neg;
`ifdef OTTER_MULDIV_DIV_EN
            r_rem_neg <= w_a_neg;
`endif
            r_p       <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            r_b       <= w_is_div ? w_b_mag : w_a_mag;
            if (w_special) r_result <= w_special_res;
        end else if (r_state == CALC) begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_result <= w_fixed;
        end
    end

    assign bus.MULDIV_RESULT = r_result;
    assign bus.MULDIV_BUSY   = (r_state == CALC);
    assign bus.MULDIV_DONE   = (r_state == FIN);

endmodule

// File: tb/tb_otter_muldiv.sv
module tb_otter_muldiv;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    otter_muldiv_if bus_if ();

    otter_muldiv dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RISC-V M-extension semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
`ifdef OTTER_MULDIV_DIV_EN
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            3'd7: begin
                if (b == 32'd0) return a;
                return a % b;
            end
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (op >= 3'd4) begin
`ifdef OTTER_MULDIV_DIV_EN
            if (b == 32'd0) return 1;
            if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
`else
            return 1;
`endif
        end
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drive one operation and wait (bounded) for DONE. Returns the result,
    // the number of edges from the accepting edge to DONE, and BUSY cycles.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit from_fin, output logic [31:0] res,
                         output int lat, output int busy_cnt);
        if (!from_fin) @(negedge clk);
        bus_if.MULDIV_OP    = op;
        bus_if.MULDIV_SRC_A = a;
        bus_if.MULDIV_SRC_B = b;
        bus_if.MULDIV_START = 1'b1;
        @(posedge clk); #1;
        bus_if.MULDIV_START = 1'b0;
        bus_if.MULDIV_SRC_A = $urandom;
        bus_if.MULDIV_SRC_B = $urandom;
        bus_if.MULDIV_OP    = 3'($urandom);
        lat      = 1;
        busy_cnt = 0;
        while (bus_if.MULDIV_DONE !== 1'b1 && lat < 40) begin
            if (bus_if.MULDIV_BUSY === 1'b1) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = bus_if.MULDIV_RESULT;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.MULDIV_START = 1'b0;
        bus_if.MULDIV_OP    = 3'd0;
        bus_if.MULDIV_SRC_A = '0;
        bus_if.MULDIV_SRC_B = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_if.MULDIV_RESULT !== 32'd0) begin
            errors++; $display("FAIL reset_result got=%h exp=%h", bus_if.MULDIV_RESULT, 32'd0);
        end
        checks++;
        if (bus_if.MULDIV_BUSY !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b exp=0", bus_if.MULDIV_BUSY);
        end
        checks++;
        if (bus_if.MULDIV_DONE !== 1'b0) begin
            errors++; $display("FAIL reset_done got=%b exp=0", bus_if.MULDIV_DONE);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [13] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5,
                                  3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd0};
        logic [31:0] as  [13] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5,
                                  32'h80000000, 32'h80000000, 32'd100, 32'd100};
        logic [31:0] bs  [13] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7};
        logic [31:0] res;
        int          lat;
        int          busy_cnt;
        for (int i = 0; i < 13; i++) begin
            do_op(ops[i], as[i], bs[i], 1'b0, res, lat, busy_cnt);
            checks++;
            if (res !== model(ops[i], as[i], bs[i])) begin
                errors++;
                $display("FAIL directed_result[%0d] op=%0d got=%h exp=%h", i, ops[i], res,
                         model(ops[i], as[i], bs[i]));
            end
            checks++;
            if (lat !== model_lat(ops[i], as[i], bs[i])) begin
                errors++;
                $display("FAIL directed_latency[%0d] op=%0d got=%0d exp=%0d", i, ops[i], lat,
                         model_lat(ops[i], as[i], bs[i]));
            end
            if (i == 0) begin
                checks++;
                if (busy_cnt !== 32) begin
                    errors++; $display("FAIL busy_cycles got=%0d exp=32", busy_cnt);
                end
            end
        end
    endtask

    task automatic test_done_pulse();
        logic [31:0] res;
        int          lat;
        int          busy_cnt;
        do_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, res, lat, busy_cnt);
        @(posedge clk); #1;
        checks++;
        if (bus_if.MULDIV_DONE !== 1'b0) begin
            errors++; $display("FAIL done_single_pulse got=%b exp=0", bus_if.MULDIV_DONE);
        end
        checks++;
        if (bus_if.MULDIV_RESULT !== model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0)) begin
            errors++;
            $display("FAIL result_hold got=%h exp=%h", bus_if.MULDIV_RESULT,
                     model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          busy_cnt;
        for (int i = 0; i < 48; i++) begin
            op = 3'($urandom);
            a  = rand_operand();
            b  = rand_operand();
            do_op(op, a, b, 1'b0, res, lat, busy_cnt);
            checks++;
            if (res !== model(op, a, b)) begin
                errors++;
                $display("FAIL random_result op=%0d a=%h b=%h got=%h exp=%h", op, a, b, res,
                         model(op, a, b));
            end
            checks++;
            if (lat !== model_lat(op, a, b)) begin
                errors++;
                $display("FAIL random_latency op=%0d a=%h b=%h got=%0d exp=%0d", op, a, b, lat,
                         model_lat(op, a, b));
            end
        end
    endtask

    // Each new op is issued in the FIN cycle of the previous one.
    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          busy_cnt;
        do_op(3'd0, 32'd3, 32'd5, 1'b0, res, lat, busy_cnt);
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom);
            a  = rand_operand();
            b  = rand_operand();
            do_op(op, a, b, 1'b1, res, lat, busy_cnt);
            checks++;
            if (res !== model(op, a, b)) begin
                errors++;
                $display("FAIL b2b_result op=%0d a=%h b=%h got=%h exp=%h", op, a, b, res,
                         model(op, a, b));
            end
            checks++;
            if (lat !== model_lat(op, a, b)) begin
                errors++;
                $display("FAIL b2b_latency op=%0d got=%0d exp=%0d", op, lat, model_lat(op, a, b));
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        bus_if.MULDIV_OP    = 3'd1;
        bus_if.MULDIV_SRC_A = a;
        bus_if.MULDIV_SRC_B = b;
        bus_if.MULDIV_START = 1'b1;
        @(posedge clk); #1;
        bus_if.MULDIV_START = 1'b0;
        lat = 1;
        while (bus_if.MULDIV_DONE !== 1'b1 && lat < 40) begin
            if (lat == 6) begin
                bus_if.MULDIV_OP    = 3'd5;
                bus_if.MULDIV_SRC_A = $urandom;
                bus_if.MULDIV_SRC_B = 32'd0;
                bus_if.MULDIV_START = 1'b1;
            end else begin
                bus_if.MULDIV_START = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus_if.MULDIV_START = 1'b0;
        checks++;
        if (bus_if.MULDIV_RESULT !== model(3'd1, a, b)) begin
            errors++;
            $display("FAIL ignored_start_result got=%h exp=%h", bus_if.MULDIV_RESULT,
                     model(3'd1, a, b));
        end
        checks++;
        if (lat !== 33) begin
            errors++; $display("FAIL ignored_start_latency got=%0d exp=33", lat);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        @(negedge clk);
        bus_if.MULDIV_OP    = 3'd0;
        bus_if.MULDIV_SRC_A = 32'd123;
        bus_if.MULDIV_SRC_B = 32'd456;
        bus_if.MULDIV_START = 1'b1;
        @(posedge clk); #1;
        bus_if.MULDIV_START = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_if.MULDIV_RESULT !== 32'd0) begin
            errors++; $display("FAIL midreset_result got=%h exp=0", bus_if.MULDIV_RESULT);
        end
        checks++;
        if (bus_if.MULDIV_BUSY !== 1'b0) begin
            errors++; $display("FAIL midreset_busy got=%b exp=0", bus_if.MULDIV_BUSY);
        end
        checks++;
        if (bus_if.MULDIV_DONE !== 1'b0) begin
            errors++; $display("FAIL midreset_done got=%b exp=0", bus_if.MULDIV_DONE);
        end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus_if.MULDIV_DONE === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++; $display("FAIL midreset_no_done got=%0d exp=0", done_seen);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        test_reset();
        test_directed();
        test_done_pulse();
        test_random();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        test_directed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
